fft_sample_expander: RTL
========================

# fft_sample_expander

Rebuilds wide FFT datapath words from the 11-bit rounded codes produced by the FFT output truncation stage. Applies a per-frame left-shift exponent and emits 27-bit words on a valid/ready stream with frame framing. Sits on the re-entry path, where stored or transmitted truncated spectra are fed back into 27-bit processing.

## Interface
- `FRAME_LEN`, default 64: samples per frame; legal range 2..4096.
- `MAX_SHIFT`, default 16: largest legal exponent. 11 + 16 = 27 bits, so the output never overflows.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_code` input 11: unsigned truncated code.
- `in_shift` input 5: exponent; sampled only on the first beat of a frame.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block can accept a beat.
- `out_data` output 27: reconstructed word.
- `out_last` output 1: marks the final beat of a frame.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: downstream accepts.
- `shift_err` output 1: one-cycle pulse when a frame-start exponent exceeds `MAX_SHIFT`.

## Operation
- Input transfer happens when `in_valid && in_ready`. Output transfer happens when `out_valid && out_ready`.
- FSM states:
  - `IDLE`: waiting for the first beat of a frame. The accepted beat latches `in_shift` (clamped) into `shift_q` and moves the FSM to `IN_FRAME`.
  - `IN_FRAME`: beats use `shift_q` and increment `cnt`. When the accepted beat has `cnt == FRAME_LEN-1`, the FSM returns to `IDLE`.
- `shift_q` ignores `in_shift` while in `IN_FRAME`.
- Clamp rule: if `in_shift > MAX_SHIFT`, then `shift_q = MAX_SHIFT` and `shift_err` pulses in the cycle after acceptance. The frame still proceeds.
- Reconstruction: `out_data = zero-extend(in_code) << shift`, computed in 27 bits. This is exact and cannot overflow.
- `out_last` is 1 on the beat where `cnt == FRAME_LEN-1`.
- Buffering:
  - One output register plus a one-entry skid register.
  - `in_ready` depends only on registered state and is 1 when the skid register is empty.
  - No beat is ever dropped or duplicated.
- Simultaneous accept and emit with a full output register and empty skid: the output register loads the new beat directly and the skid register stays empty.
- With the skid register full, `in_ready = 0` until the skid drains into the output register.
- Reset asserted mid-frame: the partial frame is discarded, the FSM returns to `IDLE`, and `cnt` is cleared. The next accepted beat starts a new frame.

## Timing
- Reset values:
  - `out_valid = 0`, `out_data = 0`, `out_last = 0`, `shift_err = 0`, `in_ready = 1`.
  - FSM in `IDLE`, `cnt = 0`, `shift_q = 0`, skid register empty.
- Latency is 1 cycle: a beat accepted at edge N is presented with `out_valid = 1` after edge N (visible in cycle N+1), provided the output register is free or draining.
- Full throughput of 1 beat/cycle holds while `out_ready = 1`.
- Under `out_ready = 0`, at most 2 beats are held: one in the output register and one in skid.
- Output stability: `out_data` and `out_last` are held stable while `out_valid && !out_ready`.
- `shift_err` is asserted for exactly one cycle per offending frame.

## Configuration
- `FFT_EXPAND_MIDPOINT_EN`
  - Defined: when `shift_q > 0`, add `1 << (shift_q-1)` to the shifted word. This reconstructs the centre of the interval that truncation collapsed. Maximum result is `(2047<<16) + (1<<15)`, which is below 2^27, so no saturation logic is needed. With `shift_q = 0`, no bias is added.
  - Undefined: pure shift with zero fill. The bias logic is absent.

## Structure
- The shared package `fft_trunc_pkg` holds:
  - `CODE_W = 11`, `WIDE_W = 27`, `SHIFT_W = 5`.
  - The `expander_state_t` enum (`IDLE`, `IN_FRAME`).
  - The default `MAX_SHIFT`.
- One sub-module, `fft_expand_skid`: a generic width-parameterised skid buffer carrying `{out_data, out_last}`.
- The FSM, counter and shift datapath live in the top level.

## Test plan
- `FRAME_LEN = 4`, `in_shift = 12` on the first beat, codes `0x7FF, 0x001, 0x000, 0x400`, `out_ready = 1` → outputs `0x7FF000, 0x001000, 0x000000, 0x400000`. `out_last` is set on the 4th beat only. Each output appears 1 cycle after its accept.
- Same frame with `FFT_EXPAND_MIDPOINT_EN` defined → outputs `0x7FF800, 0x001800, 0x000800, 0x400800`. A following frame with `in_shift = 0` and code `0x123` gives `0x000123`.
- Frame start with `in_shift = 20` and code `0x7FF` → `shift_err` pulses once, `out_data = 0x7FF0000`, and later beats of the frame also use shift 16.
- `in_valid` held high, `out_ready` low for 5 cycles, then high → `in_ready` drops after 2 accepts. `out_data` is stable during the stall. All beats emerge in order with none lost.
- `in_shift` changed mid-frame from 12 to 4 → the remaining beats still use shift 12.
- `rst_n` pulsed low after 2 beats of a 4-beat frame → all outputs return to reset values. The next 4 beats form a complete frame, with `out_last` on the 4th beat.

Source files
------------

// File: rtl/fft_trunc_pkg.sv
// Shared widths, state encoding and defaults for the FFT truncation / expansion path.
package fft_trunc_pkg;

  localparam int CODE_W            = 11;
  localparam int WIDE_W            = 27;
  localparam int SHIFT_W           = 5;
  localparam int DEFAULT_MAX_SHIFT = 16;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } expander_state_t;

endpackage

// File: rtl/fft_expand_skid.sv
// Generic one-output-register plus one-entry skid buffer on a valid/ready stream.
module fft_expand_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid_i,
  input  logic [W-1:0] s_data_i,
  output logic         s_ready_o,
  output logic         m_valid_o,
  output logic [W-1:0] m_data_o,
  input  logic         m_ready_i
);

  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic         skid_valid_q;
  logic [W-1:0] skid_data_q;
  logic         s_accept;
  logic         out_free;

  // Ready comes straight from a flop so no combinational path runs from m_ready_i upstream.
  assign s_ready_o = !skid_valid_q;
  assign s_accept  = s_valid_i && s_ready_o;
  assign out_free  = !out_valid_q || m_ready_i;

  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;

  // NOTE: the data registers are reset as well because the output word has a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_data_q   <= skid_data_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (s_accept) begin
        out_data_q  <= s_data_i;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (s_accept) begin
      skid_data_q  <= s_data_i;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fft_sample_expander.sv
// Expands 11-bit truncated FFT codes to 27-bit words with a per-frame exponent.
// Optional: define FFT_EXPAND_MIDPOINT_EN to add the half-LSB reconstruction bias.
module fft_sample_expander
  import fft_trunc_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int MAX_SHIFT = DEFAULT_MAX_SHIFT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CODE_W-1:0]  in_code,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDE_W-1:0]  out_data,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               shift_err
);

  localparam int CNT_W = $clog2(FRAME_LEN);

  expander_state_t    state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SHIFT_W-1:0] shift_q;
  logic               shift_err_q;

  logic               accept;
  logic               shift_over;
  logic [SHIFT_W-1:0] start_shift;
  logic [SHIFT_W-1:0] beat_shift;
  logic               beat_last;
  logic [WIDE_W-1:0]  beat_data;

  assign accept = in_valid && in_ready;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    shift_over  = in_shift > SHIFT_W'(MAX_SHIFT);
    start_shift = shift_over ? SHIFT_W'(MAX_SHIFT) : in_shift;
    beat_shift  = (state_q == IDLE) ? start_shift : shift_q;
    beat_last   = (state_q == IN_FRAME) && (cnt_q == CNT_W'(FRAME_LEN - 1));
    beat_data   = WIDE_W'(in_code) << beat_shift;
`ifdef FFT_EXPAND_MIDPOINT_EN
    if (beat_shift != '0) begin
      beat_data = beat_data + (WIDE_W'(1) << (beat_shift - 1'b1));
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      shift_err_q <= 1'b0;
    end else begin
      shift_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q     <= start_shift;
            shift_err_q <= shift_over;
            cnt_q       <= CNT_W'(1);
            state_q     <= IN_FRAME;
          end
        end
        IN_FRAME: begin
          if (accept) begin
            if (beat_last) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign shift_err = shift_err_q;

  fft_expand_skid #(
    .W (WIDE_W + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (in_valid),
    .s_data_i  ({beat_data, beat_last}),
    .s_ready_o (in_ready),
    .m_valid_o (out_valid),
    .m_data_o  ({out_data, out_last}),
    .m_ready_i (out_ready)
  );

endmodule
